// File: rtl/siso_iter_ctrl_pkg.sv
// siso_ctrl_pkg: shared types and defaults for the SISO iteration controller.
//   state_t      : controller FSM states
//   AW_DEF       : default step-address width (max block length 2^AW)
//   TIMEOUT_DEF  : default idle-cycle limit while draining extrinsics
//   WORD_W       : LLR / extrinsic word width
package siso_ctrl_pkg;
  localparam int AW_DEF      = 13;
  localparam int TIMEOUT_DEF = 4096;
  localparam int WORD_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/siso_iter_ctrl_if.sv
// siso_iter_ctrl_if: RAM and decoder-side bus of the iteration controller.
//   llr_*      : LLR RAM read port (1-cycle latency)
//   ext_r*     : extrinsic RAM read port (MSB = bank, 1-cycle latency)
//   ext_w*/we  : extrinsic RAM write port (MSB = bank)
//   siso_*     : block length, LLR, a-priori and extrinsic streams of the decoder
// modport master = controller side, slave = RAM/decoder side.
interface siso_iter_ctrl_if #(parameter int AW = siso_ctrl_pkg::AW_DEF);
  import siso_ctrl_pkg::*;

  logic [AW:0]       llr_raddr;
  logic [WORD_W-1:0] llr_rdata;
  logic [AW:0]       ext_raddr;
  logic [WORD_W-1:0] ext_rdata;
  logic [AW:0]       ext_waddr;
  logic [WORD_W-1:0] ext_wdata;
  logic              ext_we;
  logic [15:0]       siso_blklen;
  logic              siso_valid_blklen;
  logic [WORD_W-1:0] siso_in;
  logic              siso_valid_in;
  logic [WORD_W-1:0] siso_apriori;
  logic              siso_valid_apriori;
  logic [WORD_W-1:0] siso_extrinsic;
  logic              siso_valid_extrinsic;

  modport master (
    output llr_raddr, ext_raddr, ext_waddr, ext_wdata, ext_we,
           siso_blklen, siso_valid_blklen, siso_in, siso_valid_in,
           siso_apriori, siso_valid_apriori,
    input  llr_rdata, ext_rdata, siso_extrinsic, siso_valid_extrinsic
  );

  modport slave (
    input  llr_raddr, ext_raddr, ext_waddr, ext_wdata, ext_we,
           siso_blklen, siso_valid_blklen, siso_in, siso_valid_in,
           siso_apriori, siso_valid_apriori,
    output llr_rdata, ext_rdata, siso_extrinsic, siso_valid_extrinsic
  );
endinterface

// File: rtl/siso_feed_agen.sv
// siso_feed_agen: FEED-phase address generator.
//   i_go        : pulse (CFG cycle) that starts a pass at k=0, p=0
//   i_lm1       : block length minus one
//   i_rbank     : extrinsic bank to read a-priori values from
//   o_llr_raddr : 2k+p, one address per cycle
//   o_ext_raddr : {bank,k}, updated on parity addresses
//   o_vld_in    : LLR data strobe, one cycle after each address
//   o_vld_apri  : a-priori strobe on parity data cycles
//   o_last      : the flush cycle carrying the final LLR word
module siso_feed_agen
  import siso_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_go,
  input  logic [AW-1:0] i_lm1,
  input  logic          i_rbank,
  output logic [AW:0]   o_llr_raddr,
  output logic [AW:0]   o_ext_raddr,
  output logic          o_vld_in,
  output logic          o_vld_apri,
  output logic          o_last
);
  logic [AW-1:0] r_k;
  logic          r_p;
  logic [1:0]    vld_pipe;   // [0]: address issuing, [1]: data cycle
  logic          r_apri;
  logic [AW:0]   r_llr_raddr;
  logic [AW:0]   r_ext_raddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_p         <= 1'b0;
      vld_pipe    <= '0;
      r_apri      <= 1'b0;
      r_llr_raddr <= '0;
      r_ext_raddr <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      r_apri      <= vld_pipe[0] & r_p;
      if (i_go) begin
        vld_pipe[0] <= 1'b1;
        r_k         <= '0;
        r_p         <= 1'b0;
        r_llr_raddr <= '0;
      end else if (vld_pipe[0]) begin
        if (!r_p) begin
          r_p         <= 1'b1;
          r_llr_raddr <= {r_k, 1'b1};
          r_ext_raddr <= {i_rbank, r_k};
        end else if (r_k == i_lm1) begin
          vld_pipe[0] <= 1'b0;
          r_p         <= 1'b0;
          r_llr_raddr <= '0;
        end else begin
          r_k         <= r_k + AW'(1);
          r_p         <= 1'b0;
          r_llr_raddr <= {r_k + AW'(1), 1'b0};
        end
      end
    end
  end

  assign o_llr_raddr = r_llr_raddr;
  assign o_ext_raddr = r_ext_raddr;
  assign o_vld_in    = vld_pipe[1];
  assign o_vld_apri  = r_apri;
  // Data still in flight but no more addresses: the flush cycle.
  assign o_last      = vld_pipe[1] & ~vld_pipe[0];
endmodule

// File: rtl/siso_iter_ctrl.sv
// siso_iter_ctrl: iteration controller for the SISO decoder.
//   clk, rst   : clock, synchronous active-high reset
//   start      : block start request (accepted in IDLE only)
//   blklen_cfg : block length L, valid range 1..2^AW
//   n_iter     : iteration count (0 behaves as 1)
//   busy/done/err/iter/ext_bank : status; ext_bank holds final result bank
//   bus        : RAM and decoder streams (siso_iter_ctrl_if.master)
// Build option SISO_EXT_REVERSE_EN: extrinsic write step index is L-1-j
// (decoder emits in backward order); otherwise j.
module siso_iter_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] blklen_cfg,
  input  logic [3:0]  n_iter,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  iter,
  output logic        ext_bank,
  siso_iter_ctrl_if.master bus
);
  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0] L_MAX   = 32'd1 << AW;

  state_t            r_state;
  logic [AW:0]       r_len, r_j;
  logic [AW-1:0]     r_lm1;
  logic [3:0]        r_nlast, r_iter;
  logic [TW-1:0]     r_to;
  logic              r_busy, r_done, r_err, r_ext_bank, r_blk_vld;
  logic [15:0]       r_blklen;
  logic              r_ext_we;
  logic [AW:0]       r_ext_waddr;
  logic [WORD_W-1:0] r_ext_wdata;

  logic          w_len_ok, w_j_full, w_cap, w_final;
  logic          w_vld_in, w_vld_apri, w_feed_last;
  logic [AW:0]   w_llr_raddr, w_ext_raddr;
  logic [AW-1:0] w_widx;

  assign w_len_ok = (blklen_cfg != 16'd0) && ({16'd0, blklen_cfg} <= L_MAX);
  assign w_j_full = (r_j == r_len);
  // Strobes beyond L words are not written; bank iter[0] is never the read bank.
  assign w_cap    = ((r_state == S_FEED) || (r_state == S_DRAIN)) &&
                    bus.siso_valid_extrinsic && !w_j_full;
  assign w_final  = (r_iter == r_nlast);

`ifdef SISO_EXT_REVERSE_EN
  assign w_widx = r_lm1 - r_j[AW-1:0];
`else
  assign w_widx = r_j[AW-1:0];
`endif

  siso_feed_agen #(.AW(AW)) u_agen (
    .clk         (clk),
    .rst         (rst),
    .i_go        (r_state == S_CFG),
    .i_lm1       (r_lm1),
    .i_rbank     (~r_iter[0]),
    .o_llr_raddr (w_llr_raddr),
    .o_ext_raddr (w_ext_raddr),
    .o_vld_in    (w_vld_in),
    .o_vld_apri  (w_vld_apri),
    .o_last      (w_feed_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_j         <= '0;
      r_lm1       <= '0;
      r_nlast     <= '0;
      r_iter      <= '0;
      r_to        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ext_bank  <= 1'b0;
      r_blk_vld   <= 1'b0;
      r_blklen    <= '0;
      r_ext_we    <= 1'b0;
      r_ext_waddr <= '0;
      r_ext_wdata <= '0;
    end else begin
      r_blk_vld <= 1'b0;
      r_done    <= 1'b0;
      r_ext_we  <= 1'b0;
      if (w_cap) begin
        r_ext_we    <= 1'b1;
        r_ext_waddr <= {r_iter[0], w_widx};
        r_ext_wdata <= bus.siso_extrinsic;
        r_j         <= r_j + (AW+1)'(1);
        r_to        <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_len_ok) begin
              r_len     <= blklen_cfg[AW:0];
              r_lm1     <= blklen_cfg[AW-1:0] - AW'(1);
              r_nlast   <= (n_iter == 4'd0) ? 4'd0 : n_iter - 4'd1;
              r_iter    <= '0;
              r_err     <= 1'b0;
              r_busy    <= 1'b1;
              r_blklen  <= blklen_cfg;
              r_blk_vld <= 1'b1;
              r_j       <= '0;
              r_state   <= S_CFG;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_CFG: begin
          r_to    <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          r_to <= '0;
          if (w_feed_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_j_full) begin
            if (w_final) begin
              r_ext_bank <= r_iter[0];
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_iter    <= r_iter + 4'd1;
              r_j       <= '0;
              r_blk_vld <= 1'b1;
              r_state   <= S_CFG;
            end
          end else if (!bus.siso_valid_extrinsic) begin
            if (r_to == TO_LAST) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_to <= r_to + TW'(1);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign iter     = r_iter;
  assign ext_bank = r_ext_bank;

  assign bus.llr_raddr          = w_llr_raddr;
  assign bus.ext_raddr          = w_ext_raddr;
  assign bus.ext_waddr          = r_ext_waddr;
  assign bus.ext_wdata          = r_ext_wdata;
  assign bus.ext_we             = r_ext_we;
  assign bus.siso_blklen        = r_blklen;
  assign bus.siso_valid_blklen  = r_blk_vld;
  assign bus.siso_valid_in      = w_vld_in;
  assign bus.siso_valid_apriori = w_vld_apri;
  // The RAM output register is the pipeline stage for data words; gating with
  // the registered strobes keeps them at 0 outside data cycles and on reset.
  assign bus.siso_in      = w_vld_in ? bus.llr_rdata : '0;
  assign bus.siso_apriori = (w_vld_apri && (r_iter != 4'd0)) ? bus.ext_rdata : '0;
endmodule

// File: tb/tb_siso_iter_ctrl.sv
module tb_siso_iter_ctrl;
  localparam int AW = 4;
  localparam int TO = 64;
`ifdef SISO_EXT_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] blklen_cfg = '0;
  logic [3:0]  n_iter = '0;
  logic        busy, done, err, ext_bank;
  logic [3:0]  iter;

  siso_iter_ctrl_if #(.AW(AW)) bus ();

  siso_iter_ctrl #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .blklen_cfg(blklen_cfg), .n_iter(n_iter),
    .busy(busy), .done(done), .err(err), .iter(iter), .ext_bank(ext_bank),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  logic [15:0] llr_mem [0:31];
  logic [15:0] ext_mem [0:31];
  always @(posedge clk) begin
    bus.llr_rdata <= llr_mem[bus.llr_raddr];
    bus.ext_rdata <= ext_mem[bus.ext_raddr];
    if (bus.ext_we) ext_mem[bus.ext_waddr] <= bus.ext_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled on the falling edge.
  logic        clr_req = 1'b0;
  logic [15:0] in_d[$], ap_d[$], we_d[$], bl_v[$];
  int          in_c[$], we_a[$], we_c[$], bl_c[$], dn_c[$];
  always @(negedge clk) begin
    if (clr_req) begin
      in_d.delete(); ap_d.delete(); we_d.delete(); bl_v.delete();
      in_c.delete(); we_a.delete(); we_c.delete(); bl_c.delete(); dn_c.delete();
    end
    if (bus.siso_valid_in) begin in_d.push_back(bus.siso_in); in_c.push_back(cyc); end
    if (bus.siso_valid_apriori) ap_d.push_back(bus.siso_apriori);
    if (bus.ext_we) begin
      we_a.push_back(int'(bus.ext_waddr)); we_d.push_back(bus.ext_wdata); we_c.push_back(cyc);
    end
    if (bus.siso_valid_blklen) begin bl_c.push_back(cyc); bl_v.push_back(bus.siso_blklen); end
    if (done) dn_c.push_back(cyc);
  end

  int n_vec = 0;
  int n_err = 0;
  int c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clr();
    clr_req = 1'b1; tick(); clr_req = 1'b0;
  endtask

  task automatic startblk(input int l, input int n);
    blklen_cfg = 16'(l); n_iter = 4'(n); start = 1'b1; c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int v);
    bus.siso_extrinsic = 16'(v); bus.siso_valid_extrinsic = 1'b1;
    tick();
    bus.siso_valid_extrinsic = 1'b0;
  endtask

  task automatic wait_in(input int n, input int max);
    for (int i = 0; i < max && in_d.size() < n; i++) tick();
    chk("wait_in", in_d.size(), n);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && dn_c.size() == 0; i++) tick();
    chk("done_seen", dn_c.size(), 1);
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  function automatic int qd(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? int'(q[i]) : -1;
  endfunction
  function automatic int eidx(input int i, input int l);
    return REV ? (l - 1 - i) : i;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) llr_mem[i] = 16'(i < 8 ? i : 100 + i);
    bus.siso_extrinsic = '0; bus.siso_valid_extrinsic = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ctl", {busy, done, err, iter, ext_bank}, 0);
    chk("rst_bus", {bus.ext_we, bus.siso_valid_blklen, bus.siso_valid_in,
                    bus.siso_valid_apriori, bus.llr_raddr, bus.ext_raddr}, 0);
    rst = 1'b0;
    tick();

    // L=4, one iteration
    clr();
    startblk(4, 1);
    chk("t1_busy", busy, 1);
    wait_in(8, 40);
    for (int i = 0; i < 4; i++) send(16'h50 + i);
    wait_done(20);
    chk("t1_blk_cyc", qi(bl_c, 0), c0 + 1);
    chk("t1_blk_val", qd(bl_v, 0), 4);
    chk("t1_in_first", qi(in_c, 0), c0 + 3);
    chk("t1_in_last", qi(in_c, 7), c0 + 10);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_in%0d", i), qd(in_d, i), i);
    chk("t1_apri_n", ap_d.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_apri%0d", i), qd(ap_d, i), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_wa%0d", i), qi(we_a, i), eidx(i, 4));
      chk($sformatf("t1_wd%0d", i), qd(we_d, i), 16'h50 + i);
    end
    chk("t1_done_lat", qi(dn_c, 0), qi(we_c, 3) + 1);
    tick();
    chk("t1_post", {busy, err, ext_bank}, 0);
    chk("t1_done_once", dn_c.size(), 1);

    // L=3, two iterations
    clr();
    startblk(3, 2);
    wait_in(6, 40);
    for (int i = 0; i < 3; i++) send(10 + i);
    wait_in(12, 40);
    for (int i = 0; i < 3; i++) send(20 + i);
    wait_done(30);
    tick();
    chk("t2_blk_n", bl_c.size(), 2);
    chk("t2_cfg_gap", qi(bl_c, 1), qi(we_c, 2) + 1);
    chk("t2_feed2", qi(in_c, 6), qi(bl_c, 1) + 2);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_in2_%0d", i), qd(in_d, 6 + i), i);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_apri1_%0d", k), qd(ap_d, k), 0);
      chk($sformatf("t2_apri2_%0d", k), qd(ap_d, 3 + k), 10 + eidx(k, 3));
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_wa1_%0d", i), qi(we_a, i), eidx(i, 3));
      chk($sformatf("t2_wa2_%0d", i), qi(we_a, 3 + i), 16 + eidx(i, 3));
      chk($sformatf("t2_wd2_%0d", i), qd(we_d, 3 + i), 20 + i);
    end
    chk("t2_bank", ext_bank, 1);
    chk("t2_iter", iter, 1);

    // Out-of-range lengths
    clr();
    startblk(0, 1);
    repeat (3) tick();
    chk("t4_err0", {err, busy}, 2'b10);
    startblk(17, 1);
    repeat (3) tick();
    chk("t4_err17", {err, busy}, 2'b10);
    chk("t4_strobes", bl_c.size() + in_d.size() + dn_c.size(), 0);

    // Timeout after 2 of 4 words
    clr();
    startblk(4, 1);
    chk("t5_err_clr", err, 0);
    wait_in(8, 40);
    send(16'h70);
    send(16'h71);
    wait_done(TO + 40);
    chk("t5_err", err, 1);
    chk("t5_we_n", we_c.size(), 2);
    chk("t5_done_cyc", qi(dn_c, 0), qi(we_c, 1) + TO);

    // Reset mid-FEED, then a clean block
    clr();
    startblk(4, 1);
    wait_in(3, 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_ctl", {busy, done, err, iter, ext_bank}, 0);
    chk("t6_bus", {bus.ext_we, bus.siso_valid_blklen, bus.siso_valid_in,
                   bus.siso_valid_apriori, bus.llr_raddr, bus.ext_raddr}, 0);
    chk("t6_data", {bus.siso_in, bus.siso_apriori}, 0);
    chk("t6_data2", {bus.siso_blklen, bus.ext_wdata}, 0);
    clr();
    startblk(2, 1);
    wait_in(4, 40);
    send(16'h30);
    send(16'h31);
    wait_done(20);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_in%0d", i), qd(in_d, i), i);
    chk("t6_wa0", qi(we_a, 0), eidx(0, 2));
    chk("t6_wa1", qi(we_a, 1), eidx(1, 2));
    chk("t6_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
